screen_writer: RTL and testbench
================================

// Module: screen_writer
// PURPOSE
//  Write-side front end of the Hack frame buffer. Decodes Hack CPU data-memory writes in the
//  SCREEN map (0x4000-0x5FFF), queues them, and drives the frame buffer write port
//  (write_address/data_in/load). Also runs a hardware fill engine that sweeps all 8192 screen
//  words with one value, for clear-screen and test patterns. Sits between CPU memory and frame_buffer.
// PARAMETERS
//  FIFO_DEPTH    4       CPU-write queue entries; power of 2, >=2
//  SCREEN_WORDS  8192    words per frame (512x256/16); fill sweep length
//  ADDR_W        13      frame buffer word address width
// PORTS
//  clk              in   1   system clock; all logic on rising edge
//  reset            in   1   synchronous, active-high reset
//  cpu_address      in   15  Hack data address (addressM)
//  cpu_data         in   16  Hack write data (outM)
//  cpu_write        in   1   Hack write strobe (writeM), sampled each clk edge
//  fill_req         in   1   1-cycle pulse: request full-screen fill
//  fill_value       in   16  fill word, latched when the request is accepted
//  fill_busy        out  1   high from fill acceptance until the last fill word is issued
//  fb_write_address out  13  to frame_buffer write_address
//  fb_data_out      out  16  to frame_buffer data_in
//  fb_load          out  1   to frame_buffer load; 1 word per high cycle
//  overflow         out  1   sticky: a decoded CPU write was dropped, FIFO full
//  fifo_level       out  3   current queue occupancy (0..FIFO_DEPTH)
// BEHAVIOUR
//  Reset: fb_load=0, fb_write_address=0, fb_data_out=0, fill_busy=0, overflow=0,
//    fifo_level=0, FSM=IDLE. Mid-fill reset aborts the sweep and discards queued writes.
//  Decode: accept only when cpu_write=1 and cpu_address[14:13]==2'b10.
//    Word address = cpu_address[12:0]. All other addresses ignored, no side effect.
//  Queue: an accepted write is pushed at edge k.
//    In IDLE with the queue otherwise empty, the pop happens at edge k+1, so fb_load is high
//    in the cycle after edge k+1: 2-cycle latency, sustained 1 word/cycle.
//    Push and pop in the same cycle are both honoured, so the level is unchanged.
//    Push while full with no same-cycle pop: the write is dropped and overflow is set.
//    overflow clears only on reset. Queued writes issue in strict arrival order.
//  All fb_* outputs are registered. fb_load=0 on any cycle with no issue;
//    address and data then hold their last values.
//  FSM:
//    IDLE: drain the queue 1 word/cycle.
//      fill_req with queue empty -> FILL; fill_value is latched and fill_busy=1 at the next edge.
//      fill_req with queue non-empty -> WAIT_EMPTY; the value is latched then.
//    WAIT_EMPTY: keep draining; fill_busy=1. When the queue is empty -> FILL.
//    FILL: counter 0..SCREEN_WORDS-1 issues 1 word/cycle (addr=counter, data=latched value).
//      CPU writes still queue, up to FIFO_DEPTH; overflow rules apply.
//      After issuing word 8191 -> IDLE. fill_busy drops on the same edge as that issue.
//      Queued writes then drain on top of the filled screen.
//      A FILL lasts exactly SCREEN_WORDS consecutive fb_load cycles.
//  fill_req outside IDLE is ignored; it is not queued.
//  Counter is ADDR_W+1 bits; the terminal compare is against SCREEN_WORDS-1, with no wrap.
// STRUCTURE
//  Shared include hack_defs.vh: SCREEN_BASE (15'h4000), SCREEN_WORDS, ADDR_W,
//    and FSM state encodings IDLE/WAIT_EMPTY/FILL.
//  One sub-module: sync_fifo (DEPTH, WIDTH=29). Ports: push, pop, din, dout, full, empty, level.
//    Push/pop in the same cycle is legal.
//  Top: decode, FSM, fill counter, output registers.
// TESTING
//  1. Write addr 0x4000, data 0xFFFF -> fb_load=1 two cycles later with addr 0, data 0xFFFF; single pulse.
//  2. Writes to 0x3FFF and 0x6000 -> fb_load never asserts; fifo_level stays 0.
//  3. fill_req with fill_value 0x0000 from IDLE -> 8192 consecutive fb_load cycles, addr 0..8191,
//     data 0; fill_busy high throughout.
//  4. During fill, 5 writes with FIFO_DEPTH=4 -> overflow=1 after the 5th.
//     After word 8191, the first 4 writes issue in order.
//  5. 3 queued writes, then fill_req -> the 3 writes issue first (WAIT_EMPTY), then the fill starts.
//  6. reset asserted at fill word 100 -> next cycle fb_load=0, fill_busy=0, fifo_level=0, overflow=0.

Source files
------------

// File: rtl/screen_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : screen_writer_pkg
//  Description : Shared constants for the Hack screen write path: screen map
//                base, frame size, frame buffer address width, queue entry
//                width and the screen_writer FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package screen_writer_pkg;

    // Base of the SCREEN map in Hack data memory; bits [14:13] select it.
    localparam logic [14:0] c_SCREEN_BASE  = 15'h4000;
    localparam int          c_SCREEN_WORDS = 8192;
    localparam int          c_ADDR_W       = 13;
    localparam int          c_DATA_W       = 16;
    // One queued CPU write: {word address, data}.
    localparam int          c_ENTRY_W      = c_ADDR_W + c_DATA_W;

    // Write-path FSM encodings.
    localparam logic [1:0]  c_IDLE         = 2'd0;
    localparam logic [1:0]  c_WAIT_EMPTY   = 2'd1;
    localparam logic [1:0]  c_FILL         = 2'd2;

endpackage : screen_writer_pkg
`default_nettype wire

// File: rtl/screen_writer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with first-word-fall-through read (dout
//                always shows the oldest entry). Push and pop in the same
//                cycle are both honoured; a push while full is honoured only
//                when a pop frees a slot in the same cycle.
//  Ports       : clk, reset (sync, active-high)
//                push/din   - write request and data
//                pop/dout   - read request and head-of-queue data
//                full/empty - occupancy flags
//                level      - occupancy 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,    // power of 2, >= 2
    parameter int WIDTH = 29
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_LVL_W    = $clog2(DEPTH + 1);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_count;

    logic               w_do_push;
    logic               w_do_pop;
    logic [c_LVL_W-1:0] w_count_nxt;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL_LVL);
    assign level = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty;
    // A full queue still accepts a push when the same cycle pops.
    assign w_do_push = push && (!full || w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + c_LVL_W'(1);
            2'b01:   w_count_nxt = r_count - c_LVL_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= w_count_nxt;
        end
    end

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/screen_writer.sv
`default_nettype none
// ============================================================================
//  Module      : screen_writer
//  Description : Write-side front end of the Hack frame buffer. Decodes CPU
//                writes into the SCREEN map, queues them and issues them to
//                the frame buffer write port one word per cycle. A fill
//                engine sweeps every screen word with a single value.
//  Ports       : clk, reset (sync, active-high)
//                cpu_address/cpu_data/cpu_write - Hack data-memory write
//                fill_req/fill_value            - full-screen fill request
//                fill_busy                      - fill accepted, not finished
//                fb_write_address/fb_data_out/fb_load - frame buffer port
//                overflow   - sticky: a decoded write was dropped (queue full)
//                fifo_level - current queue occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_writer
    import screen_writer_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int SCREEN_WORDS = c_SCREEN_WORDS,
    parameter int ADDR_W       = c_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [14:0]       cpu_address,
    input  logic [15:0]       cpu_data,
    input  logic              cpu_write,
    input  logic              fill_req,
    input  logic [15:0]       fill_value,
    output logic              fill_busy,
    output logic [ADDR_W-1:0] fb_write_address,
    output logic [15:0]       fb_data_out,
    output logic              fb_load,
    output logic              overflow,
    output logic [2:0]        fifo_level
);

    localparam int                c_LVL_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                c_QW        = ADDR_W + c_DATA_W;
    // One spare counter bit so the terminal value never aliases to zero.
    localparam logic [ADDR_W:0]   c_LAST_WORD = (ADDR_W + 1)'(SCREEN_WORDS - 1);

    logic [1:0]         r_state;
    logic [ADDR_W:0]    r_fill_cnt;
    logic [15:0]        r_fill_val;
    logic               r_fill_busy;
    logic               r_overflow;
    logic               r_fb_load;
    logic [ADDR_W-1:0]  r_fb_addr;
    logic [15:0]        r_fb_data;

    logic [1:0]         w_state_nxt;
    logic [ADDR_W:0]    w_fill_cnt_nxt;
    logic [15:0]        w_fill_val_nxt;
    logic               w_fill_issue;
    logic [ADDR_W-1:0]  w_fb_addr_nxt;
    logic [15:0]        w_fb_data_nxt;

    logic               w_hit;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_LVL_W-1:0] w_fifo_level;
    logic [c_QW-1:0]    w_fifo_dout;

    // Screen map is the 8K-word window whose top two address bits are 2'b10.
    assign w_hit  = cpu_write && (cpu_address[14:13] == c_SCREEN_BASE[14:13]);
    // The queue only drains while the fill engine is not driving the port.
    assign w_pop  = !w_fifo_empty && ((r_state == c_IDLE) || (r_state == c_WAIT_EMPTY));
    assign w_push = w_hit && (!w_fifo_full || w_pop);
    assign w_drop = w_hit && w_fifo_full && !w_pop;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_QW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({cpu_address[ADDR_W-1:0], cpu_data}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_fifo_level)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        w_fill_val_nxt = r_fill_val;
        w_fill_issue   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (fill_req) begin
                    w_fill_val_nxt = fill_value;
                    w_fill_cnt_nxt = '0;
                    // Pending CPU writes go out before the sweep starts.
                    w_state_nxt    = w_fifo_empty ? c_FILL : c_WAIT_EMPTY;
                end
            end
            c_WAIT_EMPTY: begin
                if (w_fifo_empty) begin
                    w_state_nxt    = c_FILL;
                    w_fill_cnt_nxt = '0;
                end
            end
            c_FILL: begin
                w_fill_issue = 1'b1;
                if (r_fill_cnt == c_LAST_WORD) begin
                    w_state_nxt    = c_IDLE;
                    w_fill_cnt_nxt = '0;
                end else begin
                    w_fill_cnt_nxt = r_fill_cnt + (ADDR_W + 1)'(1);
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Fill and queue issue are mutually exclusive; with neither, hold values.
    always_comb begin
        w_fb_addr_nxt = r_fb_addr;
        w_fb_data_nxt = r_fb_data;
        if (w_fill_issue) begin
            w_fb_addr_nxt = r_fill_cnt[ADDR_W-1:0];
            w_fb_data_nxt = r_fill_val;
        end else if (w_pop) begin
            w_fb_addr_nxt = w_fifo_dout[c_QW-1 -: ADDR_W];
            w_fb_data_nxt = w_fifo_dout[c_DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_fill_cnt  <= '0;
            r_fill_val  <= '0;
            r_fill_busy <= 1'b0;
            r_overflow  <= 1'b0;
            r_fb_load   <= 1'b0;
            r_fb_addr   <= '0;
            r_fb_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_cnt  <= w_fill_cnt_nxt;
            r_fill_val  <= w_fill_val_nxt;
            // Busy drops on the same edge that issues the last fill word.
            r_fill_busy <= (w_state_nxt != c_IDLE);
            r_overflow  <= r_overflow | w_drop;
            r_fb_load   <= w_fill_issue | w_pop;
            r_fb_addr   <= w_fb_addr_nxt;
            r_fb_data   <= w_fb_data_nxt;
        end
    end

    assign fill_busy        = r_fill_busy;
    assign overflow         = r_overflow;
    assign fb_load          = r_fb_load;
    assign fb_write_address = r_fb_addr;
    assign fb_data_out      = r_fb_data;
    assign fifo_level       = 3'(w_fifo_level);

endmodule : screen_writer
`default_nettype wire

// File: tb/tb_screen_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_screen_writer
//  Description : Directed self-checking bench for screen_writer: reset state,
//                single write latency, address decode, back-to-back drain,
//                full-screen fill, overflow during fill, fill behind queued
//                writes and reset in the middle of a fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_writer;

    logic        clk;
    logic        reset;
    logic [14:0] cpu_address;
    logic [15:0] cpu_data;
    logic        cpu_write;
    logic        fill_req;
    logic [15:0] fill_value;
    logic        fill_busy;
    logic [12:0] fb_write_address;
    logic [15:0] fb_data_out;
    logic        fb_load;
    logic        overflow;
    logic [2:0]  fifo_level;

    int n_cmp;
    int n_err;

    screen_writer #(
        .FIFO_DEPTH   (4),
        .SCREEN_WORDS (8192),
        .ADDR_W       (13)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_address      (cpu_address),
        .cpu_data         (cpu_data),
        .cpu_write        (cpu_write),
        .fill_req         (fill_req),
        .fill_value       (fill_value),
        .fill_busy        (fill_busy),
        .fb_write_address (fb_write_address),
        .fb_data_out      (fb_data_out),
        .fb_load          (fb_load),
        .overflow         (overflow),
        .fifo_level       (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (fb_load !== 1'b0) begin n_err++; $display("FAIL reset_load got %b want 0", fb_load); end
        n_cmp++; if (fb_write_address !== 13'd0) begin n_err++; $display("FAIL reset_addr got %h want 0", fb_write_address); end
        n_cmp++; if (fb_data_out !== 16'd0) begin n_err++; $display("FAIL reset_data got %h want 0", fb_data_out); end
        n_cmp++; if (fill_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", fill_busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        cpu_address = 15'h4000; cpu_data = 16'hFFFF; cpu_write = 1'b1;
        tick();
        cpu_write = 1'b0;
        n_cmp++; if (fb_load !== 1'b0) begin n_err++; $display("FAIL single_early_load got %b want 0", fb_load); end
        n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL single_level got %0d want 1", fifo_level); end
        tick();
        n_cmp++; if (fb_load !== 1'b1) begin n_err++; $display("FAIL single_load got %b want 1", fb_load); end
        n_cmp++; if (fb_write_address !== 13'h0000) begin n_err++; $display("FAIL single_addr got %h want 0000", fb_write_address); end
        n_cmp++; if (fb_data_out !== 16'hFFFF) begin n_err++; $display("FAIL single_data got %h want ffff", fb_data_out); end
        tick();
        n_cmp++; if (fb_load !== 1'b0) begin n_err++; $display("FAIL single_pulse got %b want 0", fb_load); end
        n_cmp++; if (fb_data_out !== 16'hFFFF) begin n_err++; $display("FAIL single_data_hold got %h want ffff", fb_data_out); end
    endtask

    task automatic test_decode_ignore();
        logic [14:0] bad_addr [3];
        bad_addr[0] = 15'h3FFF; bad_addr[1] = 15'h6000; bad_addr[2] = 15'h7FFF;
        for (int i = 0; i < 3; i++) begin
            cpu_address = bad_addr[i]; cpu_data = 16'h1234; cpu_write = 1'b1;
            tick();
            cpu_write = 1'b0;
            n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL decode_level addr=%h got %0d want 0", bad_addr[i], fifo_level); end
            tick();
            n_cmp++; if (fb_load !== 1'b0) begin n_err++; $display("FAIL decode_load addr=%h got %b want 0", bad_addr[i], fb_load); end
        end
        n_cmp++; if (fb_data_out !== 16'hFFFF) begin n_err++; $display("FAIL decode_data_hold got %h want ffff", fb_data_out); end
    endtask

    task automatic test_back_to_back();
        logic [14:0] a [4];
        logic [15:0] d [4];
        logic [12:0] ea [4];
        a[0] = 15'h5FFF; a[1] = 15'h4001; a[2] = 15'h4002; a[3] = 15'h4003;
        d[0] = 16'hBEEF; d[1] = 16'h0001; d[2] = 16'h0002; d[3] = 16'h0003;
        ea[0] = 13'h1FFF; ea[1] = 13'h0001; ea[2] = 13'h0002; ea[3] = 13'h0003;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                cpu_address = a[i]; cpu_data = d[i]; cpu_write = 1'b1;
            end else begin
                cpu_write = 1'b0;
            end
            tick();
            n_cmp++; if (fb_load !== ((i >= 1 && i <= 4) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL b2b_load cycle=%0d got %b", i, fb_load); end
            n_cmp++; if (fifo_level !== ((i < 4) ? 3'd1 : 3'd0)) begin n_err++; $display("FAIL b2b_level cycle=%0d got %0d", i, fifo_level); end
            if (i >= 1) begin
                n_cmp++; if (fb_write_address !== ea[(i >= 5) ? 3 : i - 1]) begin n_err++; $display("FAIL b2b_addr cycle=%0d got %h want %h", i, fb_write_address, ea[(i >= 5) ? 3 : i - 1]); end
                n_cmp++; if (fb_data_out !== d[(i >= 5) ? 3 : i - 1]) begin n_err++; $display("FAIL b2b_data cycle=%0d got %h want %h", i, fb_data_out, d[(i >= 5) ? 3 : i - 1]); end
            end
        end
    endtask

    task automatic test_fill();
        int bad;
        int first;
        bad = 0; first = -1;
        fill_value = 16'h0000; fill_req = 1'b1;
        tick();
        fill_req = 1'b0; fill_value = 16'hFFFF;   // must not affect the latched value
        n_cmp++; if (fill_busy !== 1'b1) begin n_err++; $display("FAIL fill_busy_accept got %b want 1", fill_busy); end
        n_cmp++; if (fb_load !== 1'b0) begin n_err++; $display("FAIL fill_first_gap got %b want 0", fb_load); end
        for (int i = 0; i < 8192; i++) begin
            tick();
            if (fb_load !== 1'b1 || fb_write_address !== 13'(i) || fb_data_out !== 16'h0000 ||
                fill_busy !== ((i != 8191) ? 1'b1 : 1'b0)) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL fill_sweep bad_cycles=%0d want 0 first_bad_word=%0d", bad, first); end
        tick();
        n_cmp++; if (fb_load !== 1'b0) begin n_err++; $display("FAIL fill_end_load got %b want 0", fb_load); end
        n_cmp++; if (fill_busy !== 1'b0) begin n_err++; $display("FAIL fill_end_busy got %b want 0", fill_busy); end
    endtask

    task automatic test_fill_overflow();
        int bad;
        int first;
        bad = 0; first = -1;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre got %b want 0", overflow); end
        fill_value = 16'hA5A5; fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i < 8192; i++) begin
            if (i >= 10 && i < 15) begin
                cpu_address = 15'h4100 + 15'(i - 10); cpu_data = 16'h1000 + 16'(i - 10); cpu_write = 1'b1;
            end else begin
                cpu_write = 1'b0;
            end
            // A request during the sweep must be ignored.
            fill_req = (i == 20); fill_value = (i == 20) ? 16'h0F0F : 16'hA5A5;
            tick();
            if (fb_load !== 1'b1 || fb_write_address !== 13'(i) || fb_data_out !== 16'hA5A5 ||
                fill_busy !== ((i != 8191) ? 1'b1 : 1'b0)) begin
                bad++;
                if (first < 0) first = i;
            end
            if (i == 13) begin
                n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL ovf_level_full got %0d want 4", fifo_level); end
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow); end
            end
            if (i == 14) begin
                n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
                n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL ovf_level_drop got %0d want 4", fifo_level); end
            end
        end
        fill_req = 1'b0; cpu_write = 1'b0;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL ovf_sweep bad_cycles=%0d want 0 first_bad_word=%0d", bad, first); end
        for (int j = 0; j < 4; j++) begin
            tick();
            n_cmp++; if (fb_load !== 1'b1 || fb_write_address !== 13'h100 + 13'(j) || fb_data_out !== 16'h1000 + 16'(j)) begin
                n_err++; $display("FAIL ovf_drain%0d got load=%b addr=%h data=%h want 1 %h %h", j, fb_load, fb_write_address, fb_data_out, 13'h100 + 13'(j), 16'h1000 + 16'(j));
            end
        end
        tick();
        n_cmp++; if (fb_load !== 1'b0) begin n_err++; $display("FAIL ovf_drain_end got %b want 0", fb_load); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL ovf_level_end got %0d want 0", fifo_level); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        n_cmp++; if (fill_busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy_end got %b want 0", fill_busy); end
    endtask

    task automatic test_fill_after_queue();
        int bad;
        int first;
        bad = 0; first = -1;
        cpu_address = 15'h4010; cpu_data = 16'h0011; cpu_write = 1'b1;
        tick();
        n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL fq_level1 got %0d want 1", fifo_level); end
        cpu_address = 15'h4020; cpu_data = 16'h0022;
        tick();
        n_cmp++; if (fb_load !== 1'b1 || fb_write_address !== 13'h010 || fb_data_out !== 16'h0011) begin
            n_err++; $display("FAIL fq_w1 got load=%b addr=%h data=%h want 1 010 0011", fb_load, fb_write_address, fb_data_out);
        end
        cpu_address = 15'h4030; cpu_data = 16'h0033; fill_req = 1'b1; fill_value = 16'h5A5A;
        tick();
        cpu_write = 1'b0; fill_req = 1'b0; fill_value = 16'h0000;
        n_cmp++; if (fb_load !== 1'b1 || fb_write_address !== 13'h020 || fb_data_out !== 16'h0022) begin
            n_err++; $display("FAIL fq_w2 got load=%b addr=%h data=%h want 1 020 0022", fb_load, fb_write_address, fb_data_out);
        end
        n_cmp++; if (fill_busy !== 1'b1) begin n_err++; $display("FAIL fq_busy_wait got %b want 1", fill_busy); end
        tick();
        n_cmp++; if (fb_load !== 1'b1 || fb_write_address !== 13'h030 || fb_data_out !== 16'h0033) begin
            n_err++; $display("FAIL fq_w3 got load=%b addr=%h data=%h want 1 030 0033", fb_load, fb_write_address, fb_data_out);
        end
        tick();
        n_cmp++; if (fb_load !== 1'b0 || fill_busy !== 1'b1) begin
            n_err++; $display("FAIL fq_gap got load=%b busy=%b want 0 1", fb_load, fill_busy);
        end
        for (int i = 0; i < 8192; i++) begin
            tick();
            if (fb_load !== 1'b1 || fb_write_address !== 13'(i) || fb_data_out !== 16'h5A5A ||
                fill_busy !== ((i != 8191) ? 1'b1 : 1'b0)) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL fq_sweep bad_cycles=%0d want 0 first_bad_word=%0d", bad, first); end
        tick();
        n_cmp++; if (fb_load !== 1'b0 || fill_busy !== 1'b0) begin
            n_err++; $display("FAIL fq_end got load=%b busy=%b want 0 0", fb_load, fill_busy);
        end
    endtask

    task automatic test_reset_mid_fill();
        int bad;
        bad = 0;
        fill_value = 16'h3C3C; fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            if (i == 5 || i == 6) begin
                cpu_address = 15'h4200 + 15'(i - 5); cpu_data = 16'h7700; cpu_write = 1'b1;
            end else begin
                cpu_write = 1'b0;
            end
            tick();
            if (fb_load !== 1'b1 || fb_write_address !== 13'(i) || fb_data_out !== 16'h3C3C) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rst_pre_sweep bad_cycles=%0d want 0", bad); end
        n_cmp++; if (fifo_level !== 3'd2 || overflow !== 1'b1) begin
            n_err++; $display("FAIL rst_pre_state got level=%0d ovf=%b want 2 1", fifo_level, overflow);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (fb_load !== 1'b0) begin n_err++; $display("FAIL rst_load got %b want 0", fb_load); end
        n_cmp++; if (fill_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", fill_busy); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
        n_cmp++; if (fb_write_address !== 13'd0 || fb_data_out !== 16'd0) begin
            n_err++; $display("FAIL rst_port got addr=%h data=%h want 0 0", fb_write_address, fb_data_out);
        end
        // Aborted sweep and discarded queue: nothing may issue afterwards.
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (fb_load !== 1'b0 || fill_busy !== 1'b0) begin
                n_err++; $display("FAIL rst_quiet cycle=%0d got load=%b busy=%b want 0 0", i, fb_load, fill_busy);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; cpu_address = '0; cpu_data = '0; cpu_write = 1'b0;
        fill_req = 1'b0; fill_value = '0;
        test_reset();
        test_single_write();
        test_decode_ignore();
        test_back_to_back();
        test_fill();
        test_fill_overflow();
        test_fill_after_queue();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_screen_writer
`default_nettype wire
